ram_arbiter: RTL and testbench



---
 rtl/ram_arbiter.sv | 153 +++++++++++++++
 tb/tb_ram_arbiter.sv | 279 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : ram_arbiter
// Purpose  : Round-robin arbiter/sequencer sharing one 256x32 register-file
//            RAM port between a fetch-side (m0) and a data-side (m1)
//            requester. Each access takes IDLE -> ACCESS -> RESP (3 cycles).
//            RAM controls come straight from registers; read data returns
//            through registered per-requester ports.
// Revision : 1.0 - initial release
// ============================================================================
module ram_arbiter #(
   parameter int ADDR_W = 8,
   parameter int DATA_W = 32
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              m0_req,
   input  logic              m0_wen,
   input  logic [ADDR_W-1:0] m0_addr,
   input  logic [DATA_W-1:0] m0_wdata,
   output logic              m0_gnt,
   output logic              m0_rvalid,
   output logic              m0_wdone,
   output logic [DATA_W-1:0] m0_rdata,
   input  logic              m1_req,
   input  logic              m1_wen,
   input  logic [ADDR_W-1:0] m1_addr,
   input  logic [DATA_W-1:0] m1_wdata,
   output logic              m1_gnt,
   output logic              m1_rvalid,
   output logic              m1_wdone,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [ADDR_W-1:0] ram_addr,
   output logic [DATA_W-1:0] ram_wdata,
   output logic              ram_wen,
   input  logic [DATA_W-1:0] ram_rdata,
   output logic              busy
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   state_t              r_state;
   state_t              w_next_state;
   logic                w_gnt0;
   logic                w_gnt1;
   logic                r_prio;     // requester favoured when both ask
   logic                r_owner;    // requester owning the in-flight access
   logic                r_is_wr;    // in-flight access is a write
   logic [ADDR_W-1:0]   r_ram_addr;
   logic [DATA_W-1:0]   r_ram_wdata;
   logic                r_ram_wen;
   logic [DATA_W-1:0]   r_m0_rdata;
   logic [DATA_W-1:0]   r_m1_rdata;
   logic                r_m0_rvalid;
   logic                r_m0_wdone;
   logic                r_m1_rvalid;
   logic                r_m1_wdone;

   // Arbitration and next-state: grants only in IDLE, prio breaks ties.
   always_comb begin
      w_next_state = r_state;
      w_gnt0       = 1'b0;
      w_gnt1       = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (m0_req && (!m1_req || !r_prio)) begin
               w_gnt0 = 1'b1;
            end else if (m1_req) begin
               w_gnt1 = 1'b1;
            end
            if (m0_req || m1_req) begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_ACCESS: w_next_state = ST_RESP;
         ST_RESP:   w_next_state = ST_IDLE;
         default:   w_next_state = ST_IDLE;
      endcase
   end

   // State register.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Command latch at the grant edge, RAM strobe, and response capture.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         r_prio      <= 1'b0;
         r_owner     <= 1'b0;
         r_is_wr     <= 1'b0;
         r_ram_addr  <= '0;
         r_ram_wdata <= '0;
         r_ram_wen   <= 1'b0;
         r_m0_rdata  <= '0;
         r_m1_rdata  <= '0;
         r_m0_rvalid <= 1'b0;
         r_m0_wdone  <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m1_wdone  <= 1'b0;
      end else begin
         r_m0_rvalid <= 1'b0;
         r_m0_wdone  <= 1'b0;
         r_m1_rvalid <= 1'b0;
         r_m1_wdone  <= 1'b0;
         if (w_gnt0 || w_gnt1) begin
            r_owner     <= w_gnt1;
            r_prio      <= !w_gnt1;
            r_is_wr     <= w_gnt1 ? m1_wen   : m0_wen;
            r_ram_wen   <= w_gnt1 ? m1_wen   : m0_wen;
            r_ram_addr  <= w_gnt1 ? m1_addr  : m0_addr;
            r_ram_wdata <= w_gnt1 ? m1_wdata : m0_wdata;
         end
         if (r_state == ST_ACCESS) begin
            // Address/data stay put; only the write strobe drops.
            r_ram_wen <= 1'b0;
            if (r_is_wr) begin
               r_m0_wdone <= !r_owner;
               r_m1_wdone <= r_owner;
            end else if (r_owner) begin
               r_m1_rdata  <= ram_rdata;
               r_m1_rvalid <= 1'b1;
            end else begin
               r_m0_rdata  <= ram_rdata;
               r_m0_rvalid <= 1'b1;
            end
         end
      end
   end

   assign m0_gnt    = w_gnt0;
   assign m1_gnt    = w_gnt1;
   assign m0_rvalid = r_m0_rvalid;
   assign m0_wdone  = r_m0_wdone;
   assign m0_rdata  = r_m0_rdata;
   assign m1_rvalid = r_m1_rvalid;
   assign m1_wdone  = r_m1_wdone;
   assign m1_rdata  = r_m1_rdata;
   assign ram_addr  = r_ram_addr;
   assign ram_wdata = r_ram_wdata;
   assign ram_wen   = r_ram_wen;
   assign busy      = (r_state != ST_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_ram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_ram_arbiter
// Purpose  : Self-checking bench for ram_arbiter: behavioural RAM, a
//            transaction-level reference model, directed scenarios and
//            randomized two-requester traffic.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ram_arbiter;

   logic        clk;
   logic        resetn;
   logic        m0_req, m0_wen, m1_req, m1_wen;
   logic [7:0]  m0_addr, m1_addr;
   logic [31:0] m0_wdata, m1_wdata;
   logic        m0_gnt, m0_rvalid, m0_wdone, m1_gnt, m1_rvalid, m1_wdone;
   logic [31:0] m0_rdata, m1_rdata;
   logic [7:0]  ram_addr;
   logic [31:0] ram_wdata, ram_rdata;
   logic        ram_wen;
   logic        busy;

   int errors = 0;
   int checks = 0;

   ram_arbiter #(.ADDR_W(8), .DATA_W(32)) dut (
      .clk(clk), .resetn(resetn),
      .m0_req(m0_req), .m0_wen(m0_wen), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
      .m0_gnt(m0_gnt), .m0_rvalid(m0_rvalid), .m0_wdone(m0_wdone), .m0_rdata(m0_rdata),
      .m1_req(m1_req), .m1_wen(m1_wen), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
      .m1_gnt(m1_gnt), .m1_rvalid(m1_rvalid), .m1_wdone(m1_wdone), .m1_rdata(m1_rdata),
      .ram_addr(ram_addr), .ram_wdata(ram_wdata), .ram_wen(ram_wen),
      .ram_rdata(ram_rdata), .busy(busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
      end
   endtask

   // Power-on contents of the RAM, as a pure function of the address.
   function automatic logic [31:0] init_val(input logic [7:0] a);
      return {a, ~a, a ^ 8'h5A, a + 8'h33};
   endfunction

   // ---------------- behavioural RAM (environment) ----------------
   logic        tb_clear;
   logic [31:0] tb_mem [256];
   logic        tb_wr  [256];
   always @(posedge clk) begin
      if (tb_clear) begin
         for (int i = 0; i < 256; i++) tb_wr[i] <= 1'b0;
      end else if (ram_wen) begin
         tb_mem[ram_addr] <= ram_wdata;
         tb_wr[ram_addr]  <= 1'b1;
      end
   end
   assign ram_rdata = tb_wr[ram_addr] ? tb_mem[ram_addr] : init_val(ram_addr);

   // ---------------- reference model ----------------
   logic [31:0] ref_mem [256];
   logic        ref_wr  [256];
   int          cnt;            // cycles left before the arbiter is free again
   logic        prio;
   logic        op_owner, op_wen;
   logic [7:0]  op_addr;
   logic [31:0] op_wdata;
   logic [31:0] exp_rd0, exp_rd1;
   logic        seen0, seen1;   // gnt observed at the last falling edge
   int          glog[$];        // DUT grant order

   function automatic logic [31:0] ref_read(input logic [7:0] a);
      return ref_wr[a] ? ref_mem[a] : init_val(a);
   endfunction

   always @(negedge clk) begin
      logic       e_g0, e_g1;
      logic [3:0] e_resp;
      if (tb_clear) begin
         for (int i = 0; i < 256; i++) ref_wr[i] = 1'b0;
      end
      if (!resetn) begin
         chk("rst_busy",  busy, 0);
         chk("rst_wen",   ram_wen, 0);
         chk("rst_addr",  ram_addr, 0);
         chk("rst_wdata", ram_wdata, 0);
         chk("rst_rdata", {m0_rdata ^ m1_rdata}, 0);
         chk("rst_resp",  {m0_rvalid, m0_wdone, m1_rvalid, m1_wdone}, 0);
         // An aborted write may or may not have landed; adopt the RAM's view.
         if (cnt != 0 && op_wen) begin
            ref_wr[op_addr]  = tb_wr[op_addr];
            ref_mem[op_addr] = tb_mem[op_addr];
         end
         cnt = 0; prio = 1'b0; exp_rd0 = '0; exp_rd1 = '0;
         seen0 = 1'b0; seen1 = 1'b0;
      end else begin
         e_g0 = 1'b0; e_g1 = 1'b0;
         if (cnt == 0) begin
            if (m0_req && m1_req) begin
               e_g0 = (prio == 1'b0); e_g1 = (prio == 1'b1);
            end else begin
               e_g0 = m0_req; e_g1 = m1_req;
            end
         end
         chk("gnt",  {m0_gnt, m1_gnt}, {e_g0, e_g1});
         chk("busy", busy, cnt != 0);
         chk("ram_wen", ram_wen, (cnt == 2) && op_wen);
         if (cnt == 2) begin
            chk("ram_addr", ram_addr, op_addr);
            if (op_wen) chk("ram_wdata", ram_wdata, op_wdata);
         end
         e_resp = 4'b0000;
         if (cnt == 1) begin
            if (op_owner == 1'b0) e_resp = op_wen ? 4'b0100 : 4'b1000;
            else                  e_resp = op_wen ? 4'b0001 : 4'b0010;
         end
         chk("resp", {m0_rvalid, m0_wdone, m1_rvalid, m1_wdone}, e_resp);
         chk("m0_rdata", m0_rdata, exp_rd0);
         chk("m1_rdata", m1_rdata, exp_rd1);
         if (m0_gnt) glog.push_back(0);
         if (m1_gnt) glog.push_back(1);
         // advance the model to the next cycle
         if (cnt == 2) begin
            if (op_wen) begin
               ref_mem[op_addr] = op_wdata; ref_wr[op_addr] = 1'b1;
            end else if (op_owner) exp_rd1 = ref_read(op_addr);
            else                   exp_rd0 = ref_read(op_addr);
         end
         if (cnt != 0) begin
            cnt = cnt - 1;
         end else if (e_g0 || e_g1) begin
            op_owner = e_g1;
            op_wen   = e_g1 ? m1_wen   : m0_wen;
            op_addr  = e_g1 ? m1_addr  : m0_addr;
            op_wdata = e_g1 ? m1_wdata : m0_wdata;
            prio     = ~e_g1;
            cnt      = 2;
         end
         seen0 = m0_gnt; seen1 = m1_gnt;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic issue(input int id, input logic w, input logic [7:0] a, input logic [31:0] d);
      int   n;
      logic g;
      if (id == 0) begin m0_wen = w; m0_addr = a; m0_wdata = d; m0_req = 1'b1; end
      else         begin m1_wen = w; m1_addr = a; m1_wdata = d; m1_req = 1'b1; end
      n = 0;
      do begin
         @(negedge clk);
         g = (id == 0) ? m0_gnt : m1_gnt;
         n++;
      end while (!g && n < 40);
      if (!g) chk("gnt_timeout", 0, 1);
      @(posedge clk); #1;
      if (id == 0) m0_req = 1'b0; else m1_req = 1'b0;
   endtask

   task automatic idle(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      resetn = 1'b0; m0_req = 1'b0; m1_req = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(1);
   endtask

   task automatic new_cmd(output logic w, output logic [7:0] a, output logic [31:0] d);
      w = $urandom_range(1);
      a = ($urandom_range(3) == 0) ? 8'hFF : 8'($urandom_range(15));
      d = $urandom;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      tb_clear = 1'b1; resetn = 1'b0;
      m0_req = 0; m0_wen = 0; m0_addr = 0; m0_wdata = 0;
      m1_req = 0; m1_wen = 0; m1_addr = 0; m1_wdata = 0;
      cnt = 0; prio = 0; op_owner = 0; op_wen = 0; op_addr = 0; op_wdata = 0;
      exp_rd0 = 0; exp_rd1 = 0; seen0 = 0; seen1 = 0;
      #20 tb_clear = 1'b0;
      idle(1);
      resetn = 1'b1;
      idle(1);

      // single write then read-back
      issue(0, 1'b1, 8'h10, 32'hDEADBEEF);
      idle(3);
      issue(0, 1'b0, 8'h10, 32'h0);
      idle(3);
      chk("dir_rd10", m0_rdata, 32'hDEADBEEF);

      // simultaneous reads right after reset: m0 first
      do_reset();
      glog.delete();
      fork
         issue(0, 1'b0, 8'h01, 32'h0);
         issue(1, 1'b0, 8'h02, 32'h0);
      join
      idle(4);
      chk("simul_n",     glog.size(), 2);
      chk("simul_first", (glog.size() > 0) ? glog[0] : 9, 0);

      // fairness: both hold requests for four accesses each
      do_reset();
      glog.delete();
      fork
         begin for (int i = 0; i < 4; i++) issue(0, 1'b0, 8'(i), 32'h0); end
         begin for (int i = 0; i < 4; i++) issue(1, 1'b1, 8'(8'h80 + i), 32'(i)); end
      join
      idle(4);
      chk("fair_n", glog.size(), 8);
      for (int i = 0; i < 8 && i < glog.size(); i++) chk("fair_order", glog[i], i % 2);

      // boundary address, m1_rdata untouched by m0's read
      issue(1, 1'b0, 8'h03, 32'h0);
      idle(3);
      issue(1, 1'b1, 8'hFF, 32'h12345678);
      idle(3);
      issue(0, 1'b0, 8'hFF, 32'h0);
      idle(3);
      chk("dir_rdFF", m0_rdata, 32'h12345678);

      // command changed right after grant becomes the next command
      issue(0, 1'b1, 8'h20, 32'hAAAA0000);
      issue(0, 1'b1, 8'h21, 32'hBBBB1111);
      idle(3);
      issue(0, 1'b0, 8'h20, 32'h0);
      idle(3);
      chk("dir_rd20", m0_rdata, 32'hAAAA0000);

      // reset in the middle of a write's ACCESS cycle
      issue(0, 1'b1, 8'h40, 32'h55AA55AA);
      resetn = 1'b0;
      idle(3);
      resetn = 1'b1;
      idle(1);
      issue(0, 1'b0, 8'h40, 32'h0);
      idle(3);

      // randomized traffic from both requesters
      for (int c = 0; c < 1500; c++) begin
         @(posedge clk); #1;
         if (m0_req) begin
            if (seen0) begin
               if ($urandom_range(1) == 1) new_cmd(m0_wen, m0_addr, m0_wdata);
               else m0_req = 1'b0;
            end
         end else if ($urandom_range(2) == 0) begin
            new_cmd(m0_wen, m0_addr, m0_wdata); m0_req = 1'b1;
         end
         if (m1_req) begin
            if (seen1) begin
               if ($urandom_range(1) == 1) new_cmd(m1_wen, m1_addr, m1_wdata);
               else m1_req = 1'b0;
            end
         end else if ($urandom_range(2) == 0) begin
            new_cmd(m1_wen, m1_addr, m1_wdata); m1_req = 1'b1;
         end
      end
      m0_req = 1'b0; m1_req = 1'b0;
      idle(6);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
`default_nettype wire
